// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared op encodings, FSM states and op-decode helpers
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_SHR  = 3'b000,
    OP_SHRA = 3'b001,
    OP_SHL  = 3'b010,
    OP_ROR  = 3'b011,
    OP_ROL  = 3'b100
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_e;

  // Encodings above OP_ROL have no meaning
  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_ROL;
  endfunction

  function automatic logic op_is_rotate(input logic [2:0] op);
    return (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift/rotate by 0..STEP positions
module shift_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int CNT_W = $clog2(STEP) + 1
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] dout
);

  int comp;

  // Apply one partial shift; a zero count passes the operand through
  always_comb begin
    comp = WIDTH - int'(cnt);
    case (op)
      OP_SHR:  dout = din >> cnt;
      OP_SHRA: dout = $signed(din) >>> cnt;
      OP_SHL:  dout = din << cnt;
      OP_ROR:  dout = (din >> cnt) | (din << comp);
      OP_ROL:  dout = (din << cnt) | (din >> comp);
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - multi-cycle shifter: FSM, remaining-count and registers
module shift_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(STEP) + 1;
  localparam logic [AMT_W-1:0] STEP_AMT  = AMT_W'(STEP);
  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

  shift_state_e     state;
  logic [2:0]       op_q;
  logic             illegal_q;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] remaining;

  logic [AMT_W-1:0] start_cnt;
  logic [AMT_W-1:0] step_amt;
  logic [CNT_W-1:0] step_cnt;
  logic [WIDTH-1:0] stepped;

  // Effective count: shifts saturate at WIDTH, rotates wrap, illegal ops do nothing
  always_comb begin
    start_cnt = '0;
    if (!op_is_legal(op)) begin
      start_cnt = '0;
    end else if (op_is_rotate(op)) begin
      start_cnt = {1'b0, amt[AMT_W-2:0]};
    end else if (amt > WIDTH_AMT) begin
      start_cnt = WIDTH_AMT;
    end else begin
      start_cnt = amt;
    end
  end

  // Positions to move this cycle: min(STEP, remaining)
  always_comb begin
    step_amt = (remaining > STEP_AMT) ? STEP_AMT : remaining;
    step_cnt = CNT_W'(step_amt);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_shift_step (
    .op   (op_q),
    .din  (work),
    .cnt  (step_cnt),
    .dout (stepped)
  );

  // Control FSM. Every accepted op passes through SHIFT; the cycle that finds
  // nothing left to shift moves to DONE, so zero-count and illegal ops finish
  // one edge after acceptance and real shifts one edge after their last step.
  always_ff @(posedge Clock) begin
    if (clear) begin
      state     <= IDLE;
      op_q      <= OP_SHR;
      illegal_q <= 1'b0;
      work      <= '0;
      remaining <= '0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            op_q      <= op;
            illegal_q <= !op_is_legal(op);
            work      <= a;
            remaining <= start_cnt;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (remaining == '0) begin
            result <= work;
            done   <= 1'b1;
            err    <= illegal_q;
            state  <= DONE;
          end else begin
            work      <= stepped;
            remaining <= remaining - step_amt;
          end
        end
        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - directed self-checking bench for shift_unit (STEP=1 and STEP=4)
module tb_shift_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [5:0]  amt = '0;

  logic        busy1, done1, err1;
  logic [31:0] result1;
  logic        busy4, done4, err4;
  logic [31:0] result4;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_unit #(.WIDTH(32), .STEP(1)) u_s1 (
    .Clock (clk), .clear (clear), .start (start), .op (op), .a (a), .amt (amt),
    .busy (busy1), .done (done1), .err (err1), .result (result1)
  );

  shift_unit #(.WIDTH(32), .STEP(4)) u_s4 (
    .Clock (clk), .clear (clear), .start (start), .op (op), .a (a), .amt (amt),
    .busy (busy4), .done (done4), .err (err4), .result (result4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [5:0] am, input logic [31:0] exp_r, input int lat1,
                        input int lat4, input logic exp_err, input bit poke);
    int   c;
    int   got1;
    int   got4;
    logic e1;
    logic e4;
    logic busy_ok;
    logic quiet;
    c = 0; got1 = 0; got4 = 0; e1 = 1'b0; e4 = 1'b0; busy_ok = 1'b1; quiet = 1'b1;
    @(negedge clk);
    op = o; a = av; amt = am; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (c < 200 && (got1 == 0 || got4 == 0)) begin
      if (poke && c == 1) begin
        start = 1'b1; a = 32'h5555_AAAA; op = OP_SHL; amt = 6'd3;
      end
      @(negedge clk);
      c++;
      start = 1'b0;
      if (got1 == 0) begin
        if (busy1 !== 1'b1) busy_ok = 1'b0;
        if (done1 === 1'b1) begin got1 = c; e1 = err1; end
      end
      if (got4 == 0) begin
        if (busy4 !== 1'b1) busy_ok = 1'b0;
        if (done4 === 1'b1) begin got4 = c; e4 = err4; end
      end
    end
    chk({tag, " lat1"}, 32'(got1), 32'(lat1));
    chk({tag, " lat4"}, 32'(got4), 32'(lat4));
    chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, " err1"}, {31'd0, e1}, {31'd0, exp_err});
    chk({tag, " err4"}, {31'd0, e4}, {31'd0, exp_err});
    chk({tag, " res1"}, result1, exp_r);
    chk({tag, " res4"}, result4, exp_r);
    if (poke) begin
      repeat (40) begin
        @(negedge clk);
        if (done1 || done4 || busy1 || busy4) quiet = 1'b0;
      end
      chk({tag, " quiet"}, {31'd0, quiet}, 32'd1);
      chk({tag, " hold1"}, result1, exp_r);
      chk({tag, " hold4"}, result4, exp_r);
    end
  endtask

  initial begin
    logic quiet;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    chk("rst busy1", {31'd0, busy1}, 32'd0);
    chk("rst done1", {31'd0, done1}, 32'd0);
    chk("rst err1", {31'd0, err1}, 32'd0);
    chk("rst res1", result1, 32'd0);
    chk("rst busy4", {31'd0, busy4}, 32'd0);
    chk("rst res4", result4, 32'd0);

    run_op("shra5",   OP_SHRA, 32'hFFFF_FFF4, 6'd5,  32'hFFFF_FFFF, 6,  3, 1'b0, 1'b0);
    run_op("shr31",   OP_SHR,  32'h8000_0000, 6'd31, 32'h0000_0001, 32, 9, 1'b0, 1'b0);
    run_op("rol33",   OP_ROL,  32'h8000_0001, 6'd33, 32'h0000_0003, 2,  2, 1'b0, 1'b0);
    run_op("shl40",   OP_SHL,  32'h8000_0001, 6'd40, 32'h0000_0000, 33, 9, 1'b0, 1'b0);
    run_op("shr6",    OP_SHR,  32'hF000_0000, 6'd6,  32'h03C0_0000, 7,  3, 1'b0, 1'b1);
    run_op("shra63",  OP_SHRA, 32'h8000_0000, 6'd63, 32'hFFFF_FFFF, 33, 9, 1'b0, 1'b0);
    run_op("shra_pos",OP_SHRA, 32'h7000_0000, 6'd4,  32'h0700_0000, 5,  2, 1'b0, 1'b0);
    run_op("ror8",    OP_ROR,  32'h1234_5678, 6'd8,  32'h7812_3456, 9,  3, 1'b0, 1'b0);
    run_op("rol32",   OP_ROL,  32'h1234_5678, 6'd32, 32'h1234_5678, 1,  1, 1'b0, 1'b0);
    run_op("shl0",    OP_SHL,  32'hCAFE_F00D, 6'd0,  32'hCAFE_F00D, 1,  1, 1'b0, 1'b0);
    run_op("shl7",    OP_SHL,  32'h0000_00FF, 6'd7,  32'h0000_7F80, 8,  3, 1'b0, 1'b0);
    run_op("illegal", 3'b110,  32'h1234_5678, 6'd9,  32'h1234_5678, 1,  1, 1'b1, 1'b0);

    // clear in the third SHIFT cycle of a 20-bit shift
    @(negedge clk);
    op = OP_SHR; a = 32'hFFFF_FFFF; amt = 6'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr res1", result1, 32'd0);
    chk("clr busy1", {31'd0, busy1}, 32'd0);
    chk("clr done1", {31'd0, done1}, 32'd0);
    chk("clr res4", result4, 32'd0);
    chk("clr busy4", {31'd0, busy4}, 32'd0);
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done1 || done4 || busy1 || busy4) quiet = 1'b0;
    end
    chk("clr no resume", {31'd0, quiet}, 32'd1);

    // clear wins over start in the same cycle
    @(negedge clk);
    op = OP_SHL; a = 32'h0000_0001; amt = 6'd1; clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    chk("clr+start busy1", {31'd0, busy1}, 32'd0);
    chk("clr+start busy4", {31'd0, busy4}, 32'd0);

    // start held through SHIFT and DONE is not accepted there
    @(negedge clk);
    op = OP_SHR; a = 32'h0000_00F0; amt = 6'd0; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold done1", {31'd0, done1}, 32'd1);
    chk("hold done4", {31'd0, done4}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("done start busy1", {31'd0, busy1}, 32'd0);
    chk("done start busy4", {31'd0, busy4}, 32'd0);
    @(negedge clk);
    chk("done start idle1", {31'd0, busy1}, 32'd0);
    chk("hold res1", result1, 32'h0000_00F0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
